line_window_ctrl: RTL

Controller for the two-FIFO line buffer that feeds the 3x3 window generator in the image-processing pipeline. It tracks frame and line position and drives the write, read and flush controls of both line FIFOs. It also emits a window-valid strobe with border flags and pixel coordinates, aligned to the window datapath output. A frame state machine resynchronises on every vsync rising edge, so a corrupted frame never leaves stale lines in the FIFOs.

---
 rtl/line_window_ctrl_if.sv | 36 +++
 rtl/line_window_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/line_window_ctrl_if.sv
// Signal bundle between the video source / line FIFOs and line_window_ctrl.
// Video timing comes in and FIFO, window and status signals go out.
interface line_window_ctrl_if;
   // video_de is a valid-only qualifier: a pixel is transferred on every rising
   // clock edge where video_de=1. There is no ready/backpressure, because the
   // controller accepts or ignores each pixel in the cycle it arrives.
   logic        video_vs;
   logic        video_de;
   logic        fifo_rst;
   logic        fifo_wr_en1;
   logic        fifo_wr_en2;
   logic        fifo_rd_en;
   logic        win_de;
   logic        win_top;
   logic        win_bottom;
   logic        win_left;
   logic        win_right;
   logic [10:0] x_pos;
   logic [10:0] y_pos;
   logic        frame_err;
   logic [1:0]  state;

   modport master (
      output video_vs, video_de,
      input  fifo_rst, fifo_wr_en1, fifo_wr_en2, fifo_rd_en,
      input  win_de, win_top, win_bottom, win_left, win_right,
      input  x_pos, y_pos, frame_err, state
   );

   modport slave (
      input  video_vs, video_de,
      output fifo_rst, fifo_wr_en1, fifo_wr_en2, fifo_rd_en,
      output win_de, win_top, win_bottom, win_left, win_right,
      output x_pos, y_pos, frame_err, state
   );
endinterface

// File: rtl/line_window_ctrl.sv
// Frame/line tracker for the two-FIFO 3x3 line buffer: drives the FIFO flush,
// write and read enables, and emits the window-valid strobe with its borders.
module line_window_ctrl #(
   parameter logic [10:0] IMG_WIDTH    = 11'd1920,
   parameter logic [10:0] IMG_HEIGHT   = 11'd1080,
   parameter logic [4:0]  FLUSH_CYCLES = 5'd16
) (
   input logic               video_clk,
   input logic               rst_n,
   line_window_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FLUSH  = 2'd1,
      S_WAIT   = 2'd2,
      S_ACTIVE = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  flush_cnt_q, flush_cnt_d;
   logic [10:0] x_cnt_q, x_cnt_d;
   logic [10:0] y_cnt_q, y_cnt_d;
   logic        frame_err_q, frame_err_d;
   logic        vs_d1_q;
   logic        wr_en2_q;
   logic        s1_de_q;
   logic [10:0] s1_x_q, s1_y_q;
   logic        win_de_q, win_top_q, win_bottom_q, win_left_q, win_right_q;
   logic [10:0] x_pos_q, y_pos_q;

   logic vs_rise, pix, x_last, y_last, short_line, wr_en1;

   assign vs_rise    = bus.video_vs & ~vs_d1_q;
   assign pix        = bus.video_de & ((state_q == S_WAIT) || (state_q == S_ACTIVE));
   assign x_last     = (x_cnt_q == IMG_WIDTH - 11'd1);
   assign y_last     = (y_cnt_q == IMG_HEIGHT - 11'd1);
   // A line that ends early is closed out so the next pixel lands on the next row.
   assign short_line = (state_q == S_ACTIVE) & ~bus.video_de & (x_cnt_q != 11'd0);
   assign wr_en1     = pix & (y_cnt_q < IMG_HEIGHT - 11'd1);

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      x_cnt_d     = x_cnt_q;
      y_cnt_d     = y_cnt_q;
      frame_err_d = frame_err_q;
      if (vs_rise) begin
         state_d     = S_FLUSH;
         flush_cnt_d = 5'd0;
         x_cnt_d     = 11'd0;
         y_cnt_d     = 11'd0;
         frame_err_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_FLUSH: begin
               x_cnt_d = 11'd0;
               y_cnt_d = 11'd0;
               if (flush_cnt_q == FLUSH_CYCLES - 5'd1) begin
                  state_d     = S_WAIT;
                  flush_cnt_d = 5'd0;
               end else begin
                  flush_cnt_d = flush_cnt_q + 5'd1;
               end
            end
            default: begin
               if (pix) begin
                  state_d = (x_last && y_last) ? S_IDLE : S_ACTIVE;
                  if (x_last) begin
                     x_cnt_d = 11'd0;
                     y_cnt_d = y_last ? 11'd0 : y_cnt_q + 11'd1;
                  end else begin
                     x_cnt_d = x_cnt_q + 11'd1;
                  end
               end else if (short_line) begin
                  frame_err_d = 1'b1;
                  x_cnt_d     = 11'd0;
                  y_cnt_d     = y_last ? 11'd0 : y_cnt_q + 11'd1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge video_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         flush_cnt_q  <= 5'd0;
         x_cnt_q      <= 11'd0;
         y_cnt_q      <= 11'd0;
         frame_err_q  <= 1'b0;
         vs_d1_q      <= 1'b0;
         wr_en2_q     <= 1'b0;
         s1_de_q      <= 1'b0;
         s1_x_q       <= 11'd0;
         s1_y_q       <= 11'd0;
         win_de_q     <= 1'b0;
         win_top_q    <= 1'b0;
         win_bottom_q <= 1'b0;
         win_left_q   <= 1'b0;
         win_right_q  <= 1'b0;
         x_pos_q      <= 11'd0;
         y_pos_q      <= 11'd0;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         x_cnt_q      <= x_cnt_d;
         y_cnt_q      <= y_cnt_d;
         frame_err_q  <= frame_err_d;
         vs_d1_q      <= bus.video_vs;
         wr_en2_q     <= wr_en1;
         // Two register stages line the strobe up with the window datapath.
         s1_de_q      <= pix;
         s1_x_q       <= pix ? x_cnt_q : 11'd0;
         s1_y_q       <= pix ? y_cnt_q : 11'd0;
         win_de_q     <= s1_de_q;
         win_top_q    <= s1_de_q & (s1_y_q == 11'd0);
         win_bottom_q <= s1_de_q & (s1_y_q == IMG_HEIGHT - 11'd1);
         win_left_q   <= s1_de_q & (s1_x_q == 11'd0);
         win_right_q  <= s1_de_q & (s1_x_q == IMG_WIDTH - 11'd1);
         x_pos_q      <= s1_x_q;
         y_pos_q      <= s1_y_q;
      end
   end

   assign bus.fifo_rst    = (state_q == S_FLUSH);
   assign bus.fifo_wr_en1 = wr_en1;
   assign bus.fifo_wr_en2 = wr_en2_q;
   assign bus.fifo_rd_en  = pix & (y_cnt_q > 11'd0);
   assign bus.win_de      = win_de_q;
   assign bus.win_top     = win_top_q;
   assign bus.win_bottom  = win_bottom_q;
   assign bus.win_left    = win_left_q;
   assign bus.win_right   = win_right_q;
   assign bus.x_pos       = x_pos_q;
   assign bus.y_pos       = y_pos_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.state       = state_q;

endmodule
